sort_loader: RTL

//  Upstream stage of the combinational sorter: collects a stream of WIDTH-bit elements (valid/ready) into one packed DIM*WIDTH frame.

---
 rtl/sort_loader.sv | 135 +++++++++++++
 1 files changed

// File: rtl/sort_loader.sv
// sort_loader: front end of the combinational sorter. Collects a stream of
// WIDTH-bit elements into one packed DIM*WIDTH frame and holds that frame on
// out_data until the consumer takes it.
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready are
// both high. A producer may drop valid at any time, and data is ignored
// without ready. in_ready does not depend on in_valid. out_valid does not
// depend on out_ready.
//
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   in_valid/in_ready     element stream handshake, in_data = element
//   out_valid/out_ready   frame handshake, out_data = packed frame
//                         (element k at [k*WIDTH +: WIDTH])
//   out_count             number of real (non-pad) elements in the frame
//   state_o               FSM state (0 = FILL, 1 = FULL) for observation
//
// Optional feature, macro SORT_LOADER_PAD_EN: adds in_last. An element accepted
// with in_last closes a short frame, and the unused slots are padded with
// all-ones so they sort to the top.
module sort_loader #(
  parameter int DIM   = 10,
  parameter int WIDTH = 8,
  localparam int CW   = $clog2(DIM + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
`ifdef SORT_LOADER_PAD_EN
  input  logic                 in_last,
`endif
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DIM*WIDTH-1:0] out_data,
  output logic [CW-1:0]        out_count,
  output logic                 state_o
);

  typedef enum logic {FILL = 1'b0, FULL = 1'b1} state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [CW-1:0]        count_q, count_d;
  logic [DIM*WIDTH-1:0] data_q, data_d;

  logic          in_fire;
  logic          out_fire;
  logic [CW-1:0] slot;
  logic          last_elem;

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  // An element accepted while FULL can only land together with consumption,
  // so it always starts the next frame at slot 0.
  assign slot = (state_q == FULL) ? '0 : cnt_q;

`ifdef SORT_LOADER_PAD_EN
  assign last_elem = (slot == CW'(DIM - 1)) || in_last;
`else
  assign last_elem = (slot == CW'(DIM - 1));
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= FILL;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL: if (in_fire && last_elem) state_d = FULL;
      FULL: begin
        if (out_fire) begin
          // A one-element padded frame can close in the same cycle.
          if (in_fire && last_elem) state_d = FULL;
          else                      state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  // Output logic
  always_comb begin
    out_valid = (state_q == FULL);
    in_ready  = (state_q == FILL) ? 1'b1 : out_ready;
    state_o   = state_q;
  end

  // Datapath next-state: slot write, padding, counters
  always_comb begin
    data_d  = data_q;
    cnt_d   = cnt_q;
    count_d = count_q;
    if (in_fire) begin
      data_d[slot*WIDTH +: WIDTH] = in_data;
`ifdef SORT_LOADER_PAD_EN
      if (in_last) begin
        for (int k = 0; k < DIM; k++) begin
          if (k > int'(slot)) data_d[k*WIDTH +: WIDTH] = '1;
        end
      end
`endif
      if (last_elem) begin
        cnt_d   = '0;
        count_d = slot + CW'(1);
      end else begin
        cnt_d = slot + CW'(1);
      end
    end else if (out_fire) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      count_q <= '0;
      data_q  <= '0;
    end else begin
      cnt_q   <= cnt_d;
      count_q <= count_d;
      data_q  <= data_d;
    end
  end

  assign out_data  = data_q;
  assign out_count = count_q;

endmodule
